// File: rtl/studio2_mem_arbiter.sv
// Single-port RAM arbiter for a Studio II style system: a cartridge download
// port, video DMA and the CPU share one synchronous RAM.
// Download has top priority, then DMA, then CPU. The CPU is guaranteed a slot
// after DMA_BURST back-to-back DMA grants.
module studio2_mem_arbiter #(
  parameter logic [11:0] VRAM_BASE = 12'h900,
  parameter logic [11:0] WP_TOP    = 12'h7FF,
  parameter int unsigned DMA_BURST = 8
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  output logic        cpu_ack,
  output logic [7:0]  cpu_q,
  input  logic        dma_req,
  input  logic        dma_frame,
  output logic        dma_valid,
  output logic [7:0]  dma_q,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [11:0] dl_a,
  input  logic [7:0]  dl_d,
  output logic [11:0] mem_a,
  output logic        mem_we,
  output logic [7:0]  mem_d,
  input  logic [7:0]  mem_q,
  output logic        wp_hit
);

  localparam int unsigned BurstW = $clog2(DMA_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(DMA_BURST);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StCpuRd = 2'd1;
  localparam logic [1:0] StDmaRd = 2'd2;
  localparam logic [1:0] StDl    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              wp_hit_q, wp_hit_d;

  logic        cpu_unmapped, cpu_alias, cpu_wp, cpu_wins;
  logic [11:0] cpu_addr, dma_addr;
  logic        cpu_grant, dma_grant;

  logic [11:0] mem_a_c;
  logic        mem_we_c, cpu_ack_c, dma_valid_c;
  logic [7:0]  mem_d_c, cpu_q_c, dma_q_c;

  // CPU address decode: 0xC00-0xDFF mirrors 0x800-0x9FF by clearing bit 10.
  always_comb begin
    cpu_unmapped = |cpu_a[15:12];
    cpu_alias    = (cpu_a[11:9] == 3'b110);
    cpu_addr     = {cpu_a[11], cpu_a[10] & ~cpu_alias, cpu_a[9:0]};
    cpu_wp       = (cpu_addr <= WP_TOP);
    dma_addr     = VRAM_BASE + {4'h0, ptr_q};
    cpu_wins     = cpu_req && (!dma_req || (burst_q == BurstMax));
  end

  // Arbitration, RAM port muxing and next-state computation.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    wp_hit_d    = wp_hit_q;
    cpu_grant   = 1'b0;
    dma_grant   = 1'b0;
    mem_a_c     = '0;
    mem_we_c    = 1'b0;
    mem_d_c     = '0;
    cpu_ack_c   = 1'b0;
    cpu_q_c     = '0;
    dma_valid_c = 1'b0;
    dma_q_c     = '0;

    case (state_q)
      StIdle: begin
        if (dl_active) begin
          // Drive the download bus already on entry so no strobe is lost.
          state_d  = StDl;
          mem_a_c  = dl_a;
          mem_d_c  = dl_d;
          mem_we_c = dl_wr;
        end else if (cpu_wins) begin
          cpu_grant = 1'b1;
          if (cpu_unmapped) begin
            // No RAM access; writes vanish silently, reads float high.
            cpu_ack_c = 1'b1;
            cpu_q_c   = cpu_we ? 8'h00 : 8'hFF;
          end else if (cpu_we) begin
            cpu_ack_c = 1'b1;
            mem_a_c   = cpu_addr;
            mem_d_c   = cpu_d;
            if (cpu_wp) wp_hit_d = 1'b1;
            else        mem_we_c = 1'b1;
          end else begin
            mem_a_c = cpu_addr;
            state_d = StCpuRd;
          end
        end else if (dma_req) begin
          dma_grant = 1'b1;
          mem_a_c   = dma_addr;
          state_d   = StDmaRd;
        end
      end
      StCpuRd: begin
        cpu_ack_c = 1'b1;
        cpu_q_c   = mem_q;
        state_d   = StIdle;
      end
      StDmaRd: begin
        dma_valid_c = 1'b1;
        dma_q_c     = mem_q;
        ptr_d       = ptr_q + 8'd1;
        state_d     = StIdle;
      end
      default: begin
        if (dl_active) begin
          mem_a_c  = dl_a;
          mem_d_c  = dl_d;
          mem_we_c = dl_wr;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    if (dma_frame) ptr_d = '0;

    // Burst counter only tracks DMA grants that are starving a waiting CPU.
    if (!cpu_req || cpu_grant) begin
      burst_d = '0;
    end else if (dma_grant && (burst_q != BurstMax)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    mem_a     = resetq ? mem_a_c : '0;
    mem_we    = resetq & mem_we_c;
    mem_d     = resetq ? mem_d_c : '0;
    cpu_ack   = resetq & cpu_ack_c;
    cpu_q     = resetq ? cpu_q_c : '0;
    dma_valid = resetq & dma_valid_c;
    dma_q     = resetq ? dma_q_c : '0;
    wp_hit    = wp_hit_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      burst_q  <= '0;
      wp_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      wp_hit_q <= wp_hit_d;
    end
  end

endmodule
